csr_access_controller: RTL and testbench

Initiator side of the core's CSR bus. It accepts one CSR instruction at a time from the execute stage (CSRRW/CSRRS/CSRRC semantics), issues a read cycle on the shared CSR bus, computes the new value, issues a write cycle, and returns the old value. It sits between the pipeline and the OR-combined set of CSR responders. Each responder decodes its own address, returns its data only when selected, and asserts a request flag when it claims a read.

---
 rtl/csr_access_pkg.sv | 21 ++
 rtl/csr_access_controller_if.sv | 39 +++
 rtl/csr_access_alu.sv | 21 ++
 rtl/csr_access_controller.sv | 106 ++++++++++
 tb/tb_csr_access_controller.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_access_pkg.sv
// Shared CSR access definitions: op encodings, controller states and the
// read-only address test used by the initiator.
package csr_access_pkg;

  localparam logic [1:0] CSR_OP_ILL = 2'b00;
  localparam logic [1:0] CSR_OP_RW  = 2'b01;
  localparam logic [1:0] CSR_OP_RS  = 2'b10;
  localparam logic [1:0] CSR_OP_RC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  function automatic logic is_read_only(input logic [11:0] addr, input logic [1:0] prefix);
    return addr[11:10] == prefix;
  endfunction

endpackage

// File: rtl/csr_access_controller_if.sv
// Pipeline request/response handshake plus the shared CSR bus, seen from the
// initiator (master) and from the pipeline/responder side (slave).
interface csr_access_controller_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_address;
  logic [31:0] req_operand;
  logic        req_skip_write;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;

  logic        csrReadEnable;
  logic [11:0] csrReadAddress;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;

  modport master (
    input  req_valid, req_op, req_address, req_operand, req_skip_write,
    input  rsp_ready, csrReadData, csrRequestOutput,
    output req_ready, rsp_valid, rsp_data, rsp_error,
    output csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData
  );

  modport slave (
    output req_valid, req_op, req_address, req_operand, req_skip_write,
    output rsp_ready, csrReadData, csrRequestOutput,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
    input  csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData
  );

endinterface

// File: rtl/csr_access_alu.sv
// New CSR value for RW/RS/RC from the old value and operand.
// Purely combinational, no handshake.
module csr_access_alu
  import csr_access_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] old_value,
  input  logic [31:0] operand,
  output logic [31:0] new_value
);

  always_comb begin
    new_value = operand;
    case (op)
      CSR_OP_RS: new_value = old_value | operand;
      CSR_OP_RC: new_value = old_value & ~operand;
      default:   new_value = operand;
    endcase
  end

endmodule

// File: rtl/csr_access_controller.sv
// CSR bus initiator: read, modify, write, respond; 3 cycles to response (2 if no write).
// One op in flight; response held stable with no bus activity until rsp_ready.
module csr_access_controller
  import csr_access_pkg::*;
#(
  parameter logic [1:0] READ_ONLY_PREFIX = 2'b11
) (
  input logic                     clk,
  input logic                     rst,
  csr_access_controller_if.master bus
);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] operand_q;
  logic        skip_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic        err_q;
  logic [31:0] alu_value;
  logic        write_intended;
  logic        read_err;

  csr_access_alu u_alu (
    .op        (op_q),
    .old_value (bus.csrReadData),
    .operand   (operand_q),
    .new_value (alu_value)
  );

  // RW always counts as a write for protection, even when the write is skipped.
  assign write_intended = (op_q == CSR_OP_RW) || !skip_q;
  assign read_err = !bus.csrRequestOutput ||
                    (write_intended && is_read_only(addr_q, READ_ONLY_PREFIX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    bus.req_ready       = 1'b0;
    bus.rsp_valid       = 1'b0;
    bus.rsp_data        = '0;
    bus.rsp_error       = 1'b0;
    bus.csrReadEnable   = 1'b0;
    bus.csrReadAddress  = '0;
    bus.csrWriteEnable  = 1'b0;
    bus.csrWriteAddress = '0;
    bus.csrWriteData    = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_d = (bus.req_op == CSR_OP_ILL) ? ST_RESPOND : ST_READ;
      end
      ST_READ: begin
        bus.csrReadEnable  = 1'b1;
        bus.csrReadAddress = addr_q;
        state_d = (read_err || skip_q) ? ST_RESPOND : ST_WRITE;
      end
      ST_WRITE: begin
        bus.csrWriteEnable  = 1'b1;
        bus.csrWriteAddress = addr_q;
        bus.csrWriteData    = new_q;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = old_q;
        bus.rsp_error = err_q;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // old_q is forced to zero on error so RESPOND can drive it unconditionally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= CSR_OP_ILL;
      addr_q    <= '0;
      operand_q <= '0;
      skip_q    <= 1'b0;
      old_q     <= '0;
      new_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.req_valid) begin
        op_q      <= bus.req_op;
        addr_q    <= bus.req_address;
        operand_q <= bus.req_operand;
        skip_q    <= bus.req_skip_write;
        old_q     <= '0;
        err_q     <= (bus.req_op == CSR_OP_ILL);
      end else if (state_q == ST_READ) begin
        old_q <= read_err ? 32'd0 : bus.csrReadData;
        new_q <= alu_value;
        err_q <= read_err;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_controller.sv
// Randomized scoreboard bench for csr_access_controller with a behavioural
// CSR responder set and reference model.
module tb_csr_access_controller;
  import csr_access_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  localparam int NREG = 6;
  localparam logic [11:0] RADDR [NREG] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'hC00, 12'hC01};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_access_controller_if bus ();

  csr_access_controller #(.READ_ONLY_PREFIX(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int find(input logic [11:0] a);
    for (int i = 0; i < NREG; i++)
      if (RADDR[i] == a) return i;
    return -1;
  endfunction

  // Responder world: decodes its own addresses, ORed onto the bus.
  logic [31:0] rsp_regs  [NREG];
  logic [31:0] init_vals [NREG];
  logic        world_init = 1'b0;
  int          rk, wk;

  always_comb begin
    rk = find(bus.csrReadAddress);
    wk = find(bus.csrWriteAddress);
    bus.csrRequestOutput = bus.csrReadEnable && (rk >= 0);
    bus.csrReadData      = bus.csrRequestOutput ? rsp_regs[rk[2:0]] : 32'd0;
  end

  always @(posedge clk) begin
    if (world_init) begin
      for (int i = 0; i < NREG; i++) rsp_regs[i] <= init_vals[i];
    end else if (bus.csrWriteEnable && wk >= 0) begin
      rsp_regs[wk[2:0]] <= bus.csrWriteData;
    end
  end

  // Reference model state (driver side only).
  logic [31:0] mdl [NREG];
  int   exp_reads  = 0;
  int   exp_writes = 0;
  exp_t expq[$];
  logic done = 1'b0;

  task automatic model_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v,
                          input logic skip, output exp_t e);
    int k;
    logic wants, err;
    logic [31:0] old;
    k = find(a);
    if (op == 2'b00) begin
      e.data = 32'd0; e.err = 1'b1; e.lat = 1;
    end else begin
      exp_reads++;
      old   = (k >= 0) ? mdl[k[2:0]] : 32'd0;
      wants = (op == 2'b01) || !skip;
      err   = (k < 0) || (wants && a[11:10] == 2'b11);
      e.err  = err;
      e.data = err ? 32'd0 : old;
      e.lat  = (err || skip) ? 2 : 3;
      if (!err && !skip) begin
        exp_writes++;
        case (op)
          2'b01:   mdl[k[2:0]] = v;
          2'b10:   mdl[k[2:0]] = old | v;
          default: mdl[k[2:0]] = old & ~v;
        endcase
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v,
                       input logic skip, input int hold);
    exp_t e;
    int n;
    model_op(op, a, v, skip, e);
    expq.push_back(e);
    bus.req_op         = op;
    bus.req_address    = a;
    bus.req_operand    = v;
    bus.req_skip_write = skip;
    bus.req_valid      = 1'b1;
    bus.rsp_ready      = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid      = 1'b0;
    bus.req_op         = 2'($urandom);
    bus.req_address    = 12'($urandom);
    bus.req_operand    = $urandom;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic reset_mid_write();
    exp_t e;
    int n;
    e.data = 32'd0; e.err = 1'b0; e.lat = 3;
    expq.push_back(e);   // discarded by the monitor when reset hits
    exp_reads++;
    bus.req_op = 2'b01; bus.req_address = 12'h301; bus.req_operand = 32'hAAAA_5555;
    bus.req_skip_write = 1'b0; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.csrWriteEnable && n < 10) begin
      @(posedge clk); #1; n++;
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_address = '0;
    bus.req_operand = '0; bus.req_skip_write = 1'b0; bus.rsp_ready = 1'b0;
    init_vals[0] = 32'h0000_0000;
    init_vals[1] = 32'h0000_00F0;
    init_vals[2] = $urandom;
    init_vals[3] = $urandom;
    init_vals[4] = 32'h1234_5678;
    init_vals[5] = $urandom;
    for (int i = 0; i < NREG; i++) mdl[i] = init_vals[i];
    world_init = 1'b1;
    repeat (3) @(posedge clk);
    #1 world_init = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(2'b01, 12'h300, 32'hDEAD_BEEF, 1'b0, 0);
    do_op(2'b10, 12'h300, 32'h0, 1'b1, 0);
    do_op(2'b10, 12'h301, 32'h0F, 1'b0, 0);
    do_op(2'b11, 12'h301, 32'h3C, 1'b0, 0);
    do_op(2'b10, 12'h301, 32'h0, 1'b1, 0);
    do_op(2'b01, 12'h7FF, 32'h1111_2222, 1'b0, 0);
    do_op(2'b01, 12'hC00, 32'hFFFF_0000, 1'b0, 0);
    do_op(2'b10, 12'hC00, 32'h0, 1'b1, 0);
    do_op(2'b00, 12'h305, 32'h5, 1'b0, 0);
    reset_mid_write();
    do_op(2'b10, 12'h340, 32'h00FF_0000, 1'b0, 5);
    do_op(2'b01, 12'h305, 32'h0BAD_F00D, 1'b1, 0);
    for (int t = 0; t < 80; t++) begin
      int idx;
      logic [11:0] a;
      idx = $urandom_range(0, 8);
      if (idx < NREG) a = RADDR[idx];
      else if (idx == 6) a = 12'h7FF;
      else if (idx == 7) a = 12'hC05;
      else a = 12'h000;
      do_op(2'($urandom), a, $urandom, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end
    @(posedge clk); #1;
    done = 1'b1;
  end

  // Monitor and scoreboard: every comparison happens here.
  int   total = 0;
  int   bad   = 0;
  int   cycles = 0;
  int   rd_seen = 0;
  int   wr_seen = 0;
  logic busy = 1'b0;
  logic first = 1'b0;
  int   cyc = 0;
  logic [31:0] snap_data;
  logic        snap_err;
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cycles++;
      if (cycles > 20000) begin
        $display("FAIL watchdog: no completion after %0d cycles", cycles);
        $fatal(1, "watchdog");
      end
      if (!bus.csrReadEnable) chk("rd_addr_idle", {20'd0, bus.csrReadAddress}, 32'd0);
      if (!bus.csrWriteEnable) begin
        chk("wr_addr_idle", {20'd0, bus.csrWriteAddress}, 32'd0);
        chk("wr_data_idle", bus.csrWriteData, 32'd0);
      end
      if (!rst) begin
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_strobes", {30'd0, bus.csrReadEnable, bus.csrWriteEnable}, 32'd0);
        if (busy && expq.size() > 0) cur = expq.pop_front();
        busy = 1'b0;
      end else begin
        if (bus.csrReadEnable) rd_seen++;
        if (bus.csrWriteEnable) wr_seen++;
        if (!busy) begin
          chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
          chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
          chk("idle_strobes", {30'd0, bus.csrReadEnable, bus.csrWriteEnable}, 32'd0);
          if (bus.req_valid) begin
            busy = 1'b1; cyc = 0; first = 1'b1;
          end
        end else begin
          cyc++;
          chk("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
          if (bus.rsp_valid) begin
            chk("rsp_strobes", {30'd0, bus.csrReadEnable, bus.csrWriteEnable}, 32'd0);
            if (first) begin
              first = 1'b0;
              if (expq.size() > 0) chk("latency", cyc, expq[0].lat);
              snap_data = bus.rsp_data;
              snap_err  = bus.rsp_error;
            end else begin
              chk("hold_data", bus.rsp_data, snap_data);
              chk("hold_error", {31'd0, bus.rsp_error}, {31'd0, snap_err});
            end
            if (bus.rsp_ready) begin
              if (expq.size() == 0) fail_now("rsp_unexpected");
              else begin
                cur = expq.pop_front();
                chk("rsp_data", bus.rsp_data, cur.data);
                chk("rsp_error", {31'd0, bus.rsp_error}, {31'd0, cur.err});
              end
              busy = 1'b0;
            end
          end else if (cyc > 8) begin
            fail_now("rsp_timeout");
            if (expq.size() > 0) cur = expq.pop_front();
            busy = 1'b0;
          end
        end
      end
      if (done) begin
        for (int i = 0; i < NREG; i++) chk("final_reg", rsp_regs[i], mdl[i]);
        chk("write_count", wr_seen, exp_writes);
        chk("read_count", rd_seen, exp_reads);
        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

endmodule
